// File: rtl/sine_pkg.sv
// Shared definitions for the sine DAC output path and its capture counterpart.
package sine_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned AMP_W  = 9;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/zero_cross_detect.sv
// Midline crossing detector with hysteresis: tracks the current half-cycle and
// flags rising/falling crossings combinationally from the current sample.
module zero_cross_detect
  import sine_pkg::*;
#(
  parameter int unsigned MIDPOINT = 512,
  parameter int unsigned HYST     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s,
  output logic              rc,
  output logic              fc,
  output logic              half
);

  localparam logic [DATA_W-1:0] HI_C = DATA_W'(MIDPOINT + HYST);
  localparam logic [DATA_W-1:0] LO_C = DATA_W'(MIDPOINT - HYST);

  logic half_q;
  logic half_d;

  always_comb begin
    rc     = !half_q && (s >= HI_C);
    fc     = half_q && (s < LO_C);
    half_d = half_q;
    if (rc) begin
      half_d = 1'b1;
    end else if (fc) begin
      half_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign half = half_q;

endmodule

// File: rtl/sine_capture.sv
// Captures a parallel offset-binary waveform, folds it to amplitude/sign form,
// and locks onto midline crossings to report period and per-cycle peaks.
module sine_capture
  import sine_pkg::*;
#(
  parameter int unsigned MIDPOINT = 512,
  parameter int unsigned HYST     = 4,
  parameter int unsigned PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  output logic [AMP_W-1:0]    amp,
  output logic                sign,
  output logic                sample_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [DATA_W-1:0]   peak_max,
  output logic [DATA_W-1:0]   peak_min,
  output logic                locked,
  output logic                timeout
);

  localparam logic [DATA_W-1:0] MID_C = DATA_W'(MIDPOINT);

  logic [DATA_W-1:0]   sync1_q, s_q;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic                sign_q, sign_d;
  logic [2:0]          fill_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d, run_min_q, run_min_d;
  logic [DATA_W-1:0]   cyc_max, cyc_min;
  cap_state_t          state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic [DATA_W-1:0]   pk_max_q, pk_max_d, pk_min_q, pk_min_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic                rc, fc, half, sat, report, lose;
  logic                unused_zc;

  zero_cross_detect #(
    .MIDPOINT (MIDPOINT),
    .HYST     (HYST)
  ) u_zcd (
    .clk   (clk),
    .reset (reset),
    .s     (s_q),
    .rc    (rc),
    .fc    (fc),
    .half  (half)
  );

  assign unused_zc = ^{fc, half};

  always_comb begin
    sign_d = (s_q >= MID_C);
    amp_d  = sign_d ? AMP_W'(s_q - MID_C) : AMP_W'(MID_C - DATA_W'(1) - s_q);

    sat   = (cnt_q == '1);
    cnt_d = rc ? PERIOD_W'(1) : (sat ? cnt_q : cnt_q + PERIOD_W'(1));

    // Extremes for the cycle that ends on this sample, including the sample itself.
    cyc_max   = (s_q > run_max_q) ? s_q : run_max_q;
    cyc_min   = (s_q < run_min_q) ? s_q : run_min_q;
    run_max_d = rc ? s_q : cyc_max;
    run_min_d = rc ? s_q : cyc_min;

    state_d = state_q;
    report  = 1'b0;
    lose    = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (rc) state_d = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (rc) begin
          state_d = LOCKED;
          report  = 1'b1;
        end else if (sat) begin
          state_d = SEEK;
          lose    = 1'b1;
        end
      end
      default: state_d = SEEK;
    endcase

    pv_d      = report;
    timeout_d = lose;
    locked_d  = report ? 1'b1 : (lose ? 1'b0 : locked_q);
    period_d  = report ? cnt_q : period_q;
    pk_max_d  = report ? cyc_max : pk_max_q;
    pk_min_d  = report ? cyc_min : pk_min_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      s_q       <= '0;
      amp_q     <= '0;
      sign_q    <= 1'b0;
      fill_q    <= '0;
      cnt_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '1;
      state_q   <= SEEK;
      period_q  <= '0;
      pv_q      <= 1'b0;
      pk_max_q  <= '0;
      pk_min_q  <= '1;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= data_in;
      s_q       <= sync1_q;
      amp_q     <= amp_d;
      sign_q    <= sign_d;
      fill_q    <= {fill_q[1:0], 1'b1};
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      state_q   <= state_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      pk_max_q  <= pk_max_d;
      pk_min_q  <= pk_min_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign amp          = amp_q;
  assign sign         = sign_q;
  assign sample_valid = fill_q[2];
  assign period       = period_q;
  assign period_valid = pv_q;
  assign peak_max     = pk_max_q;
  assign peak_min     = pk_min_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/sine_capture.md
Name: sine_capture

Overview:
Receive-side counterpart of the sine DAC output path. It samples a 10-bit parallel offset-binary waveform from an external ADC or a pin loopback of the DAC bus, and folds each sample back into the 9-bit amplitude plus half-cycle sign form held in the sine ROM. It also locks onto the waveform using midline crossings with hysteresis and reports the period and peak values for each cycle. It sits between the input pins and any downstream checker or display logic.

Parameters:
MIDPOINT, 512, midline code; folding and crossing reference
HYST, 4, hysteresis half-width in codes; must satisfy MIDPOINT-HYST >= 0 and MIDPOINT+HYST <= 1023
PERIOD_W, 12, width of the period counter and period output

Ports:
clk  in  1  system clock; only clock
reset  in  1  synchronous, active-high reset
data_in  in  10  raw parallel sample, D9..D0, offset binary
amp  out  9  folded magnitude of the current sample
sign  out  1  1 = upper half-cycle (sample >= MIDPOINT)
sample_valid  out  1  high once the sync pipeline has filled after reset
period  out  PERIOD_W  clocks between the last two rising crossings
period_valid  out  1  one-cycle pulse when period and peaks update
peak_max  out  10  maximum sample over the last full cycle
peak_min  out  10  minimum sample over the last full cycle
locked  out  1  high while two or more consecutive crossings are tracked
timeout  out  1  one-cycle pulse when lock or acquisition is lost

Behaviour:
- All state resets synchronously. Every output resets to 0, except peak_min, which resets to 10'h3FF.
- Input path: data_in passes through a 2-flop synchronizer; its output is s.
- Fold, registered:
  - sign = (s >= MIDPOINT).
  - amp = sign ? s-MIDPOINT : MIDPOINT-1-s, truncated to 9 bits.
  - Latency from data_in to amp/sign is 3 clocks.
  - sample_valid rises on the 3rd clock after reset deasserts and stays high.
- Half-cycle tracker, internal register half (0 = low), reset to 0:
  - Rising crossing (rc): half==0 and s >= MIDPOINT+HYST; half is set to 1.
  - Falling crossing: half==1 and s < MIDPOINT-HYST; half is set to 0.
  - Samples inside the band never toggle half.
- Period counter cnt:
  - Loads 1 on rc; otherwise increments.
  - Saturates at 2^PERIOD_W-1 (sat).
- Running extremes run_max and run_min:
  - Updated with s every clock.
  - On rc both reload with s.
- FSM states: SEEK, MEASURE, LOCKED. Reset state is SEEK.
  - SEEK: rc -> MEASURE. Nothing is reported; this discards the partial first cycle.
  - MEASURE: rc -> LOCKED; period <= cnt; peak_max/peak_min <= run values including s; period_valid=1; locked=1. sat without rc -> SEEK; timeout=1.
  - LOCKED: each rc performs the same update as MEASURE->LOCKED. sat without rc -> SEEK; locked=0; timeout=1.
- period_valid and timeout are registered and asserted 1 clock after the rc/sat sample is present on s.
- rc and sat in the same cycle: rc wins; no timeout.
- period, peak_max and peak_min hold their last values after lock is lost until the next update or reset.
- Reset mid-operation: next clock returns to SEEK with all outputs at reset values; the synchronizer is also cleared.

Decomposition:
- Package sine_pkg:
  - DATA_W=10, AMP_W=9.
  - cap_state_t enum {SEEK, MEASURE, LOCKED}.
  - Shared with the sine generator.
- Sub-module zero_cross_detect:
  - Contains the hysteresis half tracker.
  - Inputs: clk, reset, s.
  - Outputs: rc, fc pulses, half.
  - Parameters: MIDPOINT, HYST.
- Folding, counter, extremes and FSM stay in sine_capture.

Test Plan:
1. Reset: hold reset 3 clocks with data_in=900 -> all outputs 0, peak_min=1023, sample_valid=0; sample_valid=1 exactly 3 clocks after release.
2. Fold:
   - data_in=600 -> 3 clocks later amp=88, sign=1.
   - data_in=400 -> amp=111, sign=0.
   - data_in=512 -> amp=0, sign=1.
   - data_in=511 -> amp=0, sign=0.
3. Lock: square wave of 256 clocks at 100 then 256 clocks at 900, repeating.
   - First rc: no pulse.
   - Second rc: period_valid pulse, period=512, peak_max=900, peak_min=100, locked=1.
   - Same values on every later rc.
4. Hysteresis: alternate 510/514 each clock with HYST=4 -> no rc; FSM stays SEEK; no timeouts until cnt saturates after 4095 clocks in SEEK. SEEK never pulses timeout.
5. Timeout: after lock, hold data_in=700 -> exactly 4095 clocks after the last rc, timeout pulse and locked=0. Period/peaks are retained. A new square wave re-locks after two rc.
6. Reset mid-lock: assert reset while LOCKED -> next clock locked=0, period=0, FSM in SEEK. The relock sequence from test 3 repeats identically.
